// File: rtl/vedic_mac_8x8.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mac_8x8
// Purpose  : Three-stage multiply-accumulate over LEN unsigned 8x8 products,
//            built on a Vedic (Urdhva-Tiryagbhyam) multiplier tree.
// Revision : 1.0  initial release
// ============================================================================

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_hi;
  logic cross_lo;
  logic carry1;

  assign cross_hi = a[1] & b[0];
  assign cross_lo = a[0] & b[1];
  assign carry1   = cross_hi & cross_lo;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_hi ^ cross_lo;
  assign p[2] = (a[1] & b[1]) ^ carry1;
  assign p[3] = (a[1] & b[1]) & carry1;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  // Partial products never exceed 225, so the 8-bit sum cannot wrap.
  assign p = {4'b0000, q_ll}
           + {2'b00, q_hl, 2'b00}
           + {2'b00, q_lh, 2'b00}
           + {q_hh, 4'b0000};
endmodule

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q_ll;
  logic [7:0] q_hl;
  logic [7:0] q_lh;
  logic [7:0] q_hh;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q_ll));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q_hl));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q_lh));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q_hh));

  assign p = {8'h00, q_ll}
           + {4'h0, q_hl, 4'h0}
           + {4'h0, q_lh, 4'h0}
           + {q_hh, 8'h00};
endmodule

module vedic_mac_8x8 #(
  parameter int ACC_W = 24,
  parameter int LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow
);
  localparam int                CNT_W  = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [7:0]       a_r;
  logic [7:0]       b_r;
  logic             v1;
  logic [15:0]      prod_w;
  logic [15:0]      prod_r;
  logic             v2;
  logic [ACC_W-1:0] acc;
  logic             ovf_r;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [ACC_W:0]   sum_w;
  logic             accept;
  logic             out_take;

  vedic_8x8 u_mult (.a(a_r), .b(b_r), .p(prod_w));

  assign in_ready = rst_n && (acc_cnt < LEN_C);
  // A pair arriving together with clr belongs to the aborted frame.
  assign accept   = in_valid && in_ready && !clr;
  assign out_take = (state == HOLD) && out_ready;
  assign sum_w    = {1'b0, acc} + {1'b0, ACC_W'(prod_r)};

  assign acc_out  = acc;
  assign overflow = ovf_r;

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    if (clr) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (v2 && (done_cnt == LAST_C)) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          out_valid = 1'b1;
          if (out_ready) begin
            state_nxt = ACCUM;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      v1       <= 1'b0;
      prod_r   <= '0;
      v2       <= 1'b0;
      acc      <= '0;
      ovf_r    <= 1'b0;
      acc_cnt  <= '0;
      done_cnt <= '0;
    end else if (clr) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      acc      <= '0;
      ovf_r    <= 1'b0;
      acc_cnt  <= '0;
      done_cnt <= '0;
    end else begin
      v1     <= accept;
      v2     <= v1;
      prod_r <= prod_w;
      if (accept) begin
        a_r <= a;
        b_r <= b;
      end

      // In HOLD the frame is complete, so no accept or product can collide
      // with the handshake clear.
      if (out_take) begin
        acc      <= '0;
        ovf_r    <= 1'b0;
        acc_cnt  <= '0;
        done_cnt <= '0;
      end else begin
        if (accept) begin
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (v2) begin
          acc      <= sum_w[ACC_W-1:0];
          ovf_r    <= ovf_r | sum_w[ACC_W];
          done_cnt <= done_cnt + 1'b1;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_vedic_mac_8x8.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mac_8x8
// Purpose  : Directed bench for vedic_mac_8x8 (LEN=4/ACC_W=24 and LEN=2/ACC_W=16).
// Revision : 1.0  initial release
// ============================================================================

module tb_vedic_mac_8x8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;

  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] acc_out;
  logic        overflow;

  logic        ov_in_valid;
  logic        ov_in_ready;
  logic [7:0]  ov_a;
  logic [7:0]  ov_b;
  logic        ov_out_valid;
  logic        ov_out_ready;
  logic [15:0] ov_acc;
  logic        ov_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vedic_mac_8x8 #(.ACC_W(24), .LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow)
  );

  vedic_mac_8x8 #(.ACC_W(16), .LEN(2)) u_ovf (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(ov_in_valid), .in_ready(ov_in_ready), .a(ov_a), .b(ov_b),
    .out_valid(ov_out_valid), .out_ready(ov_out_ready),
    .acc_out(ov_acc), .overflow(ov_overflow)
  );

  // Drives four pairs (byte i of av/bv) into u_dut with `gap` idle cycles
  // between them, then counts negedges until out_valid (-1 on timeout).
  task automatic run_frame(input logic [31:0] av, input logic [31:0] bv,
                           input int gap, output int lat);
    logic took;
    int   tries;
    for (int i = 0; i < 4; i++) begin
      a        = av[8*i +: 8];
      b        = bv[8*i +: 8];
      in_valid = 1'b1;
      took     = 1'b0;
      tries    = 0;
      while (!took && tries < 20) begin
        took = in_ready;
        @(posedge clk); #1;
        tries++;
      end
      in_valid = 1'b0;
      if (i < 3) repeat (gap) begin @(posedge clk); #1; end
    end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; a = 8'd5; b = 8'd5; out_ready = 1'b0;
    ov_in_valid = 1'b1; ov_a = 8'd9; ov_b = 8'd9; ov_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (acc_out !== 24'd0) begin errors++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++;
    if (ov_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ov_in_ready got %0b want 0", ov_in_ready); end
    in_valid = 1'b0; ov_in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b1;
    run_frame({8'd0, 8'd16, 8'd1, 8'd255}, {8'd200, 8'd16, 8'd1, 8'd255}, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL b2b_latency got %0d want 3", lat); end
    checks++;
    if (acc_out !== 24'd65282) begin errors++; $display("FAIL b2b_acc_out got %0d want 65282", acc_out); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %0b want 0", overflow); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_one_cycle got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_after got %0b want 1", in_ready); end
    checks++;
    if (acc_out !== 24'd0) begin errors++; $display("FAIL b2b_acc_cleared got %0d want 0", acc_out); end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    run_frame({8'd0, 8'd16, 8'd1, 8'd255}, {8'd200, 8'd16, 8'd1, 8'd255}, 0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
    a = 8'd7; b = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 24'd65282 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%0b acc=%0d ready=%0b want 1/65282/0",
                 i, out_valid, acc_out, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
    run_frame({8'd2, 8'd2, 8'd2, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3}, 0, lat);
    checks++;
    if (acc_out !== 24'd24 || lat !== 3) begin
      errors++;
      $display("FAIL bp_next_frame got acc=%0d lat=%0d want 24/3", acc_out, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_bubbles;
    int lat;
    out_ready = 1'b1;
    run_frame({8'd0, 8'd16, 8'd1, 8'd255}, {8'd200, 8'd16, 8'd1, 8'd255}, 1, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL bubble_latency got %0d want 3", lat); end
    checks++;
    if (acc_out !== 24'd65282) begin errors++; $display("FAIL bubble_acc_out got %0d want 65282", acc_out); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int lat;
    ov_out_ready = 1'b0;
    ov_a = 8'd255; ov_b = 8'd255; ov_in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    ov_in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ov_out_valid) begin lat = k; break; end
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL ovf_latency got %0d want 3", lat); end
    checks++;
    if (ov_acc !== 16'd64514) begin errors++; $display("FAIL ovf_acc_out got %0d want 64514", ov_acc); end
    checks++;
    if (ov_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ov_overflow); end
    ov_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_overflow !== 1'b0 || ov_acc !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%0b acc=%0d want 0/0", ov_overflow, ov_acc);
    end
    ov_out_ready = 1'b0;
  endtask

  task automatic test_abort(input bit use_rst);
    int lat;
    logic seen;
    out_ready = 1'b1;
    a = 8'd10; b = 8'd10; in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    if (use_rst) begin
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || acc_out !== 24'd0) begin
        errors++;
        $display("FAIL abort_rst_during got ready=%0b acc=%0d want 0/0", in_ready, acc_out);
      end
      #1 rst_n = 1'b1;
    end else begin
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0 || acc_out !== 24'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_%s_discard got seen=%0b acc=%0d ready=%0b want 0/0/1",
               use_rst ? "rst" : "clr", seen, acc_out, in_ready);
    end
    @(posedge clk); #1;
    run_frame({8'd1, 8'd1, 8'd1, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1}, 0, lat);
    checks++;
    if (acc_out !== 24'd4 || lat !== 3) begin
      errors++;
      $display("FAIL abort_%s_next_frame got acc=%0d lat=%0d want 4/3",
               use_rst ? "rst" : "clr", acc_out, lat);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    @(posedge clk); #1;
    test_bubbles();
    @(posedge clk); #1;
    test_overflow();
    @(posedge clk); #1;
    test_abort(1'b0);
    @(posedge clk); #1;
    test_abort(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
